hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 85 ++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// In-order issue scoreboard: a shift chain of in-flight register writes gates decode
// on read-after-write hazards, with flush kill, pending-write count and stall statistics.
module hazard_scoreboard #(
  parameter int unsigned REGW    = 3,
  parameter int unsigned DEPTH   = 3,
  parameter int unsigned WBYPASS = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           id_valid,
  input  logic                           rarf,
  input  logic                           rbrf,
  input  logic                           rawf,
  input  logic                           rbwf,
  input  logic [REGW-1:0]                ra,
  input  logic [REGW-1:0]                rb,
  input  logic                           flush,
  output logic                           stall,
  output logic                           iss_valid,
  output logic [$clog2(DEPTH+1)-1:0]     pend_cnt,
  output logic [15:0]                    stall_cnt,
  output logic                           err
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  // With a write-through register file the oldest stage is already visible to readers.
  localparam int MatchN = (WBYPASS != 0) ? int'(DEPTH) - 1 : int'(DEPTH);

  logic [DEPTH-1:0] v_q, v_d;
  logic [REGW-1:0]  wreg_q [DEPTH];
  logic [REGW-1:0]  wreg_d [DEPTH];
  logic [CntW-1:0]  pend_q, pend_d;
  logic [15:0]      stall_cnt_q, stall_cnt_d;
  logic             err_q, err_d;
  logic             match_a, match_b;

  always_comb begin
    match_a = 1'b0;
    match_b = 1'b0;
    for (int i = 0; i < MatchN; i++) begin
      if (v_q[i] && (wreg_q[i] == ra)) match_a = 1'b1;
      if (v_q[i] && (wreg_q[i] == rb)) match_b = 1'b1;
    end
    stall     = id_valid & ~flush & ((rarf & match_a) | (rbrf & match_b));
    iss_valid = id_valid & ~flush & ~stall;
  end

  always_comb begin
    v_d       = '0;
    v_d[0]    = iss_valid & (rawf | rbwf);
    wreg_d[0] = rawf ? ra : rb;
    for (int i = 1; i < int'(DEPTH); i++) begin
      // Flush kills only the entry leaving stage 0.
      v_d[i]    = v_q[i-1] & ~(flush & (i == 1));
      wreg_d[i] = wreg_q[i-1];
    end
    pend_d = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      pend_d = pend_d + CntW'(v_d[i]);
    end
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    err_d = err_q | (iss_valid & rawf & rbwf);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q         <= '0;
      pend_q      <= '0;
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      v_q         <= v_d;
      pend_q      <= pend_d;
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
    end
    wreg_q <= wreg_d;
  end

  assign pend_cnt  = pend_q;
  assign stall_cnt = stall_cnt_q;
  assign err       = err_q;

endmodule
